serial_subtractor_8bit: RTL

SERIAL_SUBTRACTOR_8BIT -- requirements
Module: serial_subtractor_8bit

---
 rtl/serial_subtractor_8bit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: computes (a - b - b_in) mod 2^WIDTH one bit per clock,
// LSB first, through a single 1-bit full subtractor. The result and borrow-out
// are published only when the operation completes, and then held until the
// next completion.
module serial_subtractor_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One-bit full subtractor; returns {borrow_next, difference_bit}.
  function automatic logic [1:0] full_sub(input logic ai, input logic bi, input logic brw);
    logic d;
    logic bn;
    d  = ai ^ bi ^ brw;
    bn = (~ai & bi) | (~(ai ^ bi) & brw);
    return {bn, d};
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             b_out_q, b_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [1:0]       fs_res;
  logic [WIDTH:0]   res_shift;

  // Current bit of the serial subtraction and the result register shifted
  // with that bit entering at the MSB end.
  always_comb begin
    fs_res    = full_sub(a_sh_q[0], b_sh_q[0], brw_q);
    res_shift = {fs_res[0], res_q};
  end

  // State register plus all datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      b_out_q <= b_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: accept start only in IDLE, run WIDTH bits, pulse DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so busy/done leave flops directly.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      IDLE: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
      RUN: begin
        busy_d = 1'b1;
        done_d = 1'b0;
      end
      DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture on accept, one bit per RUN cycle, and a single
  // publish of diff/b_out on the last bit so no partial result is visible.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    diff_d  = diff_q;
    b_out_d = b_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d = a;
          b_sh_d = b;
          brw_d  = b_in;
          cnt_d  = '0;
          res_d  = '0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1'b1;
        b_sh_d = b_sh_q >> 1'b1;
        brw_d  = fs_res[1];
        res_d  = res_shift[WIDTH:1];
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          diff_d  = res_shift[WIDTH:1];
          b_out_d = fs_res[1];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign diff  = diff_q;
  assign b_out = b_out_q;

endmodule
